// File: rtl/lsu_pkg.sv
// Shared opcode, funct3 and FSM encodings for the load/store unit.
package lsu_pkg;

    localparam logic [6:0] INST_TYPE_L = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S = 7'b0100011;

    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;
    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_BUSY = 2'd1;
    localparam logic [1:0] LSU_RESP = 2'd2;

endpackage

// File: rtl/lsu_if.sv
// Data RAM req/ack bus between the LSU (master) and the RAM (slave).
interface lsu_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication, byte enables, misalignment
// check on the incoming op, and extraction/extension of the returned word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_misalign,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store lane replication and byte enables; loads drive no lanes.
    always_comb begin
        o_wdata = 32'h0000_0000;
        o_be    = 4'b0000;
        if (i_is_store) begin
            case (i_funct3)
                INST_SB: begin
                    o_wdata = {4{i_store_data[7:0]}};
                    o_be    = 4'b0001 << i_addr_lo;
                end
                INST_SH: begin
                    o_wdata = {2{i_store_data[15:0]}};
                    o_be    = 4'b0011 << i_addr_lo;
                end
                INST_SW: begin
                    o_wdata = i_store_data;
                    o_be    = 4'b1111;
                end
                default: begin
                    o_wdata = 32'h0000_0000;
                    o_be    = 4'b0000;
                end
            endcase
        end else begin
            o_wdata = 32'h0000_0000;
            o_be    = 4'b0000;
        end
    end

    // funct3[1:0] gives the access size for both loads and stores.
    always_comb begin
        o_misalign = 1'b0;
        case (i_funct3[1:0])
            2'b01:   o_misalign = i_addr_lo[0];
            2'b10:   o_misalign = (i_addr_lo != 2'b00);
            default: o_misalign = 1'b0;
        endcase
    end

    // Byte and halfword lane selection from the latched address offset.
    always_comb begin
        w_byte = 8'h00;
        case (i_ld_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_ld_addr_lo[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
    end

    // Sign or zero extension by load type.
    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (i_ld_funct3)
            INST_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            INST_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
            INST_LW:  o_ld_data = i_rdata;
            INST_LBU: o_ld_data = {24'h00_0000, w_byte};
            INST_LHU: o_ld_data = {16'h0000, w_half};
            default:  o_ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes mem ops, runs the req/ack FSM with an ack
// timeout, and returns the aligned load result to the MEM stage.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic        valid_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    lsu_if.master       bus,
    output logic [31:0] mem_data_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [8:0] LP_TIMEOUT = 9'(TIMEOUT);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_data;
    logic        r_misalign;
    logic        r_bus_err;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_mem_op;
    logic        w_misalign;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_ld_data;
    logic [8:0]  w_cnt_next;
    logic        w_stall;
    logic        w_unused;

    assign w_opcode   = inst_i[6:0];
    assign w_funct3   = inst_i[14:12];
    assign w_mem_op   = valid_i & (w_is_load | w_is_store);
    assign w_cnt_next = {1'b0, r_cnt} + 9'd1;
    assign w_unused   = &{1'b0, inst_i[31:15], inst_i[11:7]};

    // Decode: only the listed funct3 values count as mem ops.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        if (w_opcode == INST_TYPE_L) begin
            case (w_funct3)
                INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU: w_is_load = 1'b1;
                default: w_is_load = 1'b0;
            endcase
        end else if (w_opcode == INST_TYPE_S) begin
            case (w_funct3)
                INST_SB, INST_SH, INST_SW: w_is_store = 1'b1;
                default: w_is_store = 1'b0;
            endcase
        end else begin
            w_is_load  = 1'b0;
            w_is_store = 1'b0;
        end
    end

    lsu_align u_align (
        .i_is_store   (w_is_store),
        .i_funct3     (w_funct3),
        .i_addr_lo    (addr_i[1:0]),
        .i_store_data (store_data_i),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_rdata      (bus.mem_rdata_i),
        .o_wdata      (w_wdata),
        .o_be         (w_be),
        .o_misalign   (w_misalign),
        .o_ld_data    (w_ld_data)
    );

    // Stall must be combinational so the op seen in IDLE freezes the pipe at once.
    always_comb begin
        w_stall = 1'b0;
        if (rst) begin
            w_stall = 1'b0;
        end else if (r_state == LSU_BUSY) begin
            w_stall = 1'b1;
        end else if ((r_state == LSU_IDLE) && w_mem_op) begin
            w_stall = 1'b1;
        end else begin
            w_stall = 1'b0;
        end
    end

    // FSM, wait counter, latched request fields and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LSU_IDLE;
            r_cnt      <= 8'd0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
            r_be       <= 4'b0000;
            r_funct3   <= 3'b000;
            r_addr_lo  <= 2'b00;
            r_data     <= 32'h0000_0000;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    r_misalign <= 1'b0;
                    r_bus_err  <= 1'b0;
                    if (w_mem_op && w_misalign) begin
                        r_misalign <= 1'b1;
                        r_data     <= 32'h0000_0000;
                        r_state    <= LSU_RESP;
                    end else if (w_mem_op) begin
                        r_req     <= 1'b1;
                        r_we      <= w_is_store;
                        r_addr    <= {addr_i[31:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_be      <= w_be;
                        r_funct3  <= w_funct3;
                        r_addr_lo <= addr_i[1:0];
                        r_cnt     <= 8'd0;
                        r_state   <= LSU_BUSY;
                    end else begin
                        r_state <= LSU_IDLE;
                    end
                end
                LSU_BUSY: begin
                    // An ack on the final wait cycle still wins over the timeout.
                    if (bus.mem_ack_i) begin
                        r_req   <= 1'b0;
                        r_data  <= r_we ? 32'h0000_0000 : w_ld_data;
                        r_state <= LSU_RESP;
                    end else if (w_cnt_next == LP_TIMEOUT) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_data    <= 32'h0000_0000;
                        r_state   <= LSU_RESP;
                    end else begin
                        r_cnt <= w_cnt_next[7:0];
                    end
                end
                LSU_RESP: begin
                    r_misalign <= 1'b0;
                    r_bus_err  <= 1'b0;
                    r_state    <= LSU_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= LSU_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_o   = r_req;
    assign bus.mem_we_o    = r_we;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_wdata_o = r_wdata;
    assign bus.mem_be_o    = r_be;
    assign mem_data_o      = r_data;
    assign stall_o         = w_stall;
    assign misalign_o      = r_misalign;
    assign bus_err_o       = r_bus_err;

endmodule
